// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the four-phase request/acknowledge handshake blocks
// (transmit side here, receive side elsewhere).
//   hs_state_t  : handshake FSM state encoding, also exported as a debug port
//   HS_MIN_SYNC : smallest legal synchronizer depth
// ---------------------------------------------------------------------------
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_DROP = 2'd2
  } hs_state_t;

  localparam int HS_MIN_SYNC = 2;

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a single level signal crossing into clk.
// Depth is clamped to at least HS_MIN_SYNC so a misconfigured instance still
// gets a metastability-safe chain.
// Ports:
//   clk  : destination clock
//   rstb : asynchronous active-low reset, all stages clear to 0
//   i_d  : asynchronous level input
//   o_q  : synchronized level (last stage)
// ---------------------------------------------------------------------------
module sync_chain
  import hs_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_d,
  output logic o_q
);

  localparam int DEPTH = (STAGES < HS_MIN_SYNC) ? HS_MIN_SYNC : STAGES;

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/multi_pulse_handshake_tx.sv
// ---------------------------------------------------------------------------
// multi_pulse_handshake_tx
// Source half of a four-phase req/ack handshake carrying per-channel event
// masks to a remote clock domain. Events arriving during a transfer are
// counted per channel and merged into later requests.
//
// Handshake protocol (four-phase, level based):
//   1. req_out rises with ch_out already valid; ch_out is frozen while req_out=1.
//   2. The remote raises ack_in once it has captured ch_out.
//   3. req_out falls after the synchronized ack is seen high.
//   4. The remote drops ack_in; once the synchronized ack is low the
//      transfer is complete (done_pulse) and a new request may start.
//   A request is never launched while the synchronized ack is still high.
//
// Ports:
//   clk, rstb    : clock, asynchronous active-low reset
//   pulse_in     : one-cycle event pulses, one bit per channel
//   ack_in       : remote acknowledge level (asynchronous)
//   clr_ovf      : clears all sticky overflow flags (a same-cycle set wins)
//   req_out      : request level to the remote domain
//   ch_out       : channel mask carried by the current request
//   done_pulse   : one-cycle pulse when a handshake completes
//   busy         : high whenever the FSM is not idle
//   overflow     : sticky per-channel "event lost at saturation" flag
//   dbg_state    : current FSM state
// All outputs are registered.
// ---------------------------------------------------------------------------
module multi_pulse_handshake_tx
  import hs_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic              ack_in,
  input  logic              clr_ovf,
  output logic              req_out,
  output logic [NUM_CH-1:0] ch_out,
  output logic              done_pulse,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow,
  output hs_state_t         dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_ack_sync;
  logic [NUM_CH-1:0] w_pend_nz;
  logic              w_launch;
  hs_state_t         w_state_nxt;

  hs_state_t         r_state;
  logic              r_req;
  logic [NUM_CH-1:0] r_ch;
  logic              r_done;
  logic              r_busy;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rstb (rstb),
    .i_d  (ack_in),
    .o_q  (w_ack_sync)
  );

  // Per-channel pending counter and sticky overflow flag.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             w_inc;
    logic             w_dec;
    logic             w_sat;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    assign w_inc          = pulse_in[gi];
    assign w_dec          = w_launch & w_pend_nz[gi];
    assign w_sat          = (r_cnt == CNT_MAX);
    assign w_pend_nz[gi]  = (r_cnt != '0);
    assign overflow[gi]   = r_ovf;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        // Increment and decrement together cancel, so a saturated counter
        // that is also being drained absorbs the new event without overflow.
        if (w_inc && !w_dec) begin
          if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (w_dec && !w_inc) begin
          r_cnt <= r_cnt - 1'b1;
        end

        if (w_inc && !w_dec && w_sat) begin
          r_ovf <= 1'b1;
        end else if (clr_ovf) begin
          r_ovf <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      HS_IDLE: begin
        // A still-high synchronized ack is a leftover from the remote side;
        // wait for it to clear before opening a new transfer.
        if ((|w_pend_nz) && !w_ack_sync) begin
          w_state_nxt = HS_REQ;
          w_launch    = 1'b1;
        end
      end
      HS_REQ: begin
        if (w_ack_sync) begin
          w_state_nxt = HS_DROP;
        end
      end
      HS_DROP: begin
        if (!w_ack_sync) begin
          w_state_nxt = HS_IDLE;
        end
      end
      default: begin
        w_state_nxt = HS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= HS_IDLE;
      r_req   <= 1'b0;
      r_ch    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == HS_REQ);
      r_busy  <= (w_state_nxt != HS_IDLE);
      r_done  <= (r_state == HS_DROP) && (w_state_nxt == HS_IDLE);
      // Mask only changes at request launch, so it is frozen for the whole
      // time req_out is high.
      if (w_launch) begin
        r_ch <= w_pend_nz;
      end
    end
  end

  assign req_out    = r_req;
  assign ch_out     = r_ch;
  assign done_pulse = r_done;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_multi_pulse_handshake_tx.sv
module tb_multi_pulse_handshake_tx;
  import hs_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic              clr_ovf = 1'b0;
  logic              ack_in;
  logic              req_out;
  logic [NUM_CH-1:0] ch_out;
  logic              done_pulse;
  logic              busy;
  logic [NUM_CH-1:0] overflow;
  hs_state_t         dbg_state;

  logic ack_remote;
  logic ack_manual = 1'b0;
  logic remote_en  = 1'b0;
  int   ack_dly    = 2;
  int   ack_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  assign ack_in = remote_en ? ack_remote : ack_manual;

  multi_pulse_handshake_tx #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .pulse_in   (pulse_in),
    .ack_in     (ack_in),
    .clr_ovf    (clr_ovf),
    .req_out    (req_out),
    .ch_out     (ch_out),
    .done_pulse (done_pulse),
    .busy       (busy),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- remote receiver model ----------------
  // ack follows req after ack_dly+1 cycles; reset together with the DUT.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ack_remote <= 1'b0;
      ack_cnt    <= 0;
    end else if (req_out != ack_remote) begin
      if (ack_cnt >= ack_dly) begin
        ack_remote <= req_out;
        ack_cnt    <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  // Transaction-level: pending events per channel as plain integers. When a
  // request is seen, the expected mask is every channel the model holds an
  // event for (before this edge's new pulses), and one event per masked
  // channel is consumed.
  logic [NUM_CH-1:0] samp_pulse;
  logic              samp_clr;
  int                m_pend [NUM_CH];
  logic [NUM_CH-1:0] m_ovf;
  logic [NUM_CH-1:0] m_mask;
  logic [NUM_CH-1:0] exp_q [$];
  logic              req_prev;
  int                req_rises = 0;
  int                done_seen = 0;
  int                ch_reqs [NUM_CH];

  always @(posedge clk) begin
    samp_pulse <= pulse_in;
    samp_clr   <= clr_ovf;
  end

  always @(negedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < NUM_CH; i++) m_pend[i] = 0;
      m_ovf = '0;
      exp_q.delete();
    end else begin
      if (req_out && !req_prev) begin
        for (int i = 0; i < NUM_CH; i++) m_mask[i] = (m_pend[i] > 0);
        exp_q.push_back(m_mask);
        req_rises++;
        for (int i = 0; i < NUM_CH; i++) begin
          if (m_pend[i] > 0) m_pend[i]--;
          if (ch_out[i]) ch_reqs[i]++;
        end
        m_mask = exp_q.pop_front();
        chk_cnt++;
        if (ch_out !== m_mask)
          $display("FAIL model_ch_out t=%0t: got %b expected %b", $time, ch_out, m_mask);
        else
          pass_cnt++;
      end
      if (samp_clr) m_ovf = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (samp_pulse[i]) begin
          if (m_pend[i] == CNT_MAX) m_ovf[i] = 1'b1;
          else m_pend[i]++;
        end
      end
      if (done_pulse) done_seen++;
      chk_cnt++;
      if (overflow !== m_ovf)
        $display("FAIL model_overflow t=%0t: got %b expected %b", $time, overflow, m_ovf);
      else
        pass_cnt++;
    end
    req_prev = req_out;
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) ch_reqs[i] = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rstb     = 1'b0;
    pulse_in = '0;
    clr_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int n = 0;
    while (quiet < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy && !req_out) quiet++;
      else quiet = 0;
    end
    chk_cnt++;
    if (quiet < 12) $display("FAIL wait_quiet: still busy=%b after %0d cycles, expected idle", busy, n);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (req_out !== 1'b0) $display("FAIL reset_req: got %b expected 0", req_out); else pass_cnt++;
    chk_cnt++; if (ch_out !== '0) $display("FAIL reset_ch: got %b expected 0000", ch_out); else pass_cnt++;
    chk_cnt++; if (done_pulse !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_pulse); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (overflow !== '0) $display("FAIL reset_ovf: got %b expected 0000", overflow); else pass_cnt++;
    chk_cnt++; if (dbg_state !== HS_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, HS_IDLE); else pass_cnt++;
    @(negedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic test_single();
    int dones = 0;
    remote_en = 1'b1;
    ack_dly   = 2;
    @(negedge clk); pulse_in = 4'b0001;
    @(negedge clk); pulse_in = '0;
    chk_cnt++; if (req_out !== 1'b0) $display("FAIL single_lat1: req_out got %b expected 0", req_out); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL single_lat2: req_out got %b expected 1", req_out); else pass_cnt++;
    chk_cnt++; if (ch_out !== 4'b0001) $display("FAIL single_ch: got %b expected 0001", ch_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else pass_cnt++;
    repeat (40) begin
      @(negedge clk);
      if (done_pulse) dones++;
    end
    chk_cnt++; if (dones != 1) $display("FAIL single_done: got %0d pulses expected 1", dones); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_idle: busy got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (ch_out !== 4'b0001) $display("FAIL single_hold: ch_out got %b expected 0001", ch_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk); pulse_in = 4'b0001;
    @(negedge clk); pulse_in = '0;
    @(negedge clk); pulse_in = 4'b0101;
    @(negedge clk); pulse_in = '0;
    chk_cnt++; if (req_out !== 1'b1 || ch_out !== 4'b0001)
      $display("FAIL b2b_first: req=%b ch=%b expected req=1 ch=0001", req_out, ch_out); else pass_cnt++;
    while (!done_pulse && n < 200) begin @(negedge clk); n++; end
    chk_cnt++; if (!done_pulse) $display("FAIL b2b_done: no done_pulse within %0d cycles", n); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL b2b_second_req: got %b expected 1", req_out); else pass_cnt++;
    chk_cnt++; if (ch_out !== 4'b0101) $display("FAIL b2b_second_ch: got %b expected 0101", ch_out); else pass_cnt++;
    wait_quiet();
    n = 0;
    for (int i = 0; i < NUM_CH; i++) n += m_pend[i];
    chk_cnt++; if (n != 0) $display("FAIL b2b_drained: model pending %0d expected 0", n); else pass_cnt++;
  endtask

  task automatic test_simul_pulse_launch();
    int r0 = ch_reqs[1];
    @(negedge clk); pulse_in = 4'b0010;
    @(negedge clk); pulse_in = 4'b0010;
    @(negedge clk); pulse_in = '0;
    chk_cnt++; if (req_out !== 1'b1 || ch_out !== 4'b0010)
      $display("FAIL simul_first: req=%b ch=%b expected req=1 ch=0010", req_out, ch_out); else pass_cnt++;
    wait_quiet();
    chk_cnt++; if (ch_reqs[1] - r0 != 2) $display("FAIL simul_count: got %0d requests expected 2", ch_reqs[1] - r0); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int r0 = ch_reqs[2];
    ack_dly = 60;
    @(negedge clk); pulse_in = 4'b0100;
    @(negedge clk); pulse_in = '0;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL ovf_req: got %b expected 1", req_out); else pass_cnt++;
    repeat (20) begin @(negedge clk); pulse_in = 4'b0100; end
    @(negedge clk); pulse_in = '0;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL ovf_held: req got %b expected 1", req_out); else pass_cnt++;
    chk_cnt++; if (overflow !== 4'b0100) $display("FAIL ovf_set: got %b expected 0100", overflow); else pass_cnt++;
    ack_dly = 2;
    wait_quiet();
    chk_cnt++; if (ch_reqs[2] - r0 != 16) $display("FAIL ovf_drain: got %0d requests expected 16", ch_reqs[2] - r0); else pass_cnt++;
    chk_cnt++; if (overflow !== 4'b0100) $display("FAIL ovf_sticky: got %b expected 0100", overflow); else pass_cnt++;
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk_cnt++; if (overflow !== '0) $display("FAIL ovf_clear: got %b expected 0000", overflow); else pass_cnt++;
  endtask

  task automatic test_stale_ack();
    int hi = 0;
    remote_en  = 1'b0;
    ack_manual = 1'b1;
    apply_reset();
    repeat (4) @(negedge clk);
    pulse_in = 4'b0001;
    @(negedge clk); pulse_in = '0;
    repeat (10) begin @(negedge clk); if (req_out) hi++; end
    chk_cnt++; if (hi != 0) $display("FAIL stale_hold: req high %0d cycles expected 0", hi); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL stale_busy: got %b expected 0", busy); else pass_cnt++;
    ack_manual = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (req_out !== 1'b0) $display("FAIL stale_early: req got %b expected 0", req_out); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1 || ch_out !== 4'b0001)
      $display("FAIL stale_req: req=%b ch=%b expected req=1 ch=0001", req_out, ch_out); else pass_cnt++;
    ack_manual = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL stale_req_hold: got %b expected 1", req_out); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (req_out !== 1'b0 || busy !== 1'b1 || dbg_state !== HS_DROP)
      $display("FAIL stale_drop: req=%b busy=%b state=%0d expected 0 1 %0d", req_out, busy, dbg_state, HS_DROP); else pass_cnt++;
    ack_manual = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (done_pulse !== 1'b0) $display("FAIL stale_done_early: got %b expected 0", done_pulse); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done_pulse !== 1'b1 || busy !== 1'b0)
      $display("FAIL stale_done: done=%b busy=%b expected 1 0", done_pulse, busy); else pass_cnt++;
    remote_en = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rises0;
    int dones = 0;
    ack_dly = 40;
    @(negedge clk); pulse_in = 4'b0011;
    @(negedge clk); pulse_in = 4'b0100;
    @(negedge clk); pulse_in = '0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (req_out !== 1'b1) $display("FAIL mid_pre: req got %b expected 1", req_out); else pass_cnt++;
    #2 rstb = 1'b0;
    #1;
    chk_cnt++; if (req_out !== 1'b0) $display("FAIL mid_req: got %b expected 0", req_out); else pass_cnt++;
    chk_cnt++; if (ch_out !== '0) $display("FAIL mid_ch: got %b expected 0000", ch_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (2) @(negedge clk);
    #1 rstb = 1'b1;
    ack_dly = 2;
    rises0 = req_rises;
    repeat (40) begin @(negedge clk); if (done_pulse) dones++; end
    chk_cnt++; if (dones != 0) $display("FAIL mid_no_done: got %0d pulses expected 0", dones); else pass_cnt++;
    chk_cnt++; if (req_rises != rises0) $display("FAIL mid_no_req: got %0d requests expected 0", req_rises - rises0); else pass_cnt++;
  endtask

  task automatic test_random();
    int r0 = req_rises;
    int d0 = done_seen;
    int n  = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      pulse_in = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      clr_ovf  = ($urandom_range(0, 59) == 0);
      ack_dly  = $urandom_range(0, 5);
    end
    @(negedge clk);
    pulse_in = '0;
    clr_ovf  = 1'b0;
    ack_dly  = 2;
    wait_quiet();
    for (int i = 0; i < NUM_CH; i++) n += m_pend[i];
    chk_cnt++; if (n != 0) $display("FAIL rand_drained: model pending %0d expected 0", n); else pass_cnt++;
    chk_cnt++; if (done_seen - d0 != req_rises - r0)
      $display("FAIL rand_done_count: got %0d done expected %0d", done_seen - d0, req_rises - r0); else pass_cnt++;
    chk_cnt++; if (req_rises - r0 < 20)
      $display("FAIL rand_activity: got %0d requests expected at least 20", req_rises - r0); else pass_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_pulse_launch();
    test_overflow();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multi_pulse_handshake_tx.md
# multi_pulse_handshake_tx

Source-side half of a four-phase request/acknowledge handshake for NUM_CH independent event channels. Events that arrive while a transfer is in flight are counted, not dropped, and merged into the next request. The block runs entirely in the sending clock domain. It drives a level request toward a remote domain and brings the remote acknowledge back in through an internal synchronizer chain. The remote receiver decodes the per-channel mask carried with each request.

## Interface
Parameters:
- NUM_CH, 4, number of event channels (1..32)
- CNT_W, 4, width of each per-channel pending counter (saturates at 2^CNT_W-1)
- SYNC_STAGES, 2, flop depth of the ack_in synchronizer (>=2)

Ports:
- clk, input, 1, single clock
- rstb, input, 1, reset, asynchronous, active-low
- pulse_in, input, NUM_CH, one-cycle event pulses, one bit per channel
- ack_in, input, 1, acknowledge level from the remote domain, asynchronous to clk
- clr_ovf, input, 1, clears all overflow flags
- req_out, output, 1, request level to the remote domain
- ch_out, output, NUM_CH, mask of channels carried by the current request; stable whenever req_out=1
- done_pulse, output, 1, one-cycle pulse when a handshake completes
- busy, output, 1, high in any state other than IDLE
- overflow, output, NUM_CH, sticky per-channel flag: an event arrived while that channel's counter was saturated

## Operation
- Per-channel pending counter pend[i]:
  - +1 on pulse_in[i]; saturates at max and sets overflow[i].
  - Decrement and increment in the same cycle: net unchanged.
- ack_sync is ack_in passed through SYNC_STAGES flops. Only ack_sync is used internally.
- FSM states: IDLE, REQ, DROP.
  - IDLE: if any pend!=0 and ack_sync==0, go to REQ. On that edge: ch_out <= mask of channels with pend!=0, and every masked counter decrements by 1. If ack_sync==1 (stale remote ack), stay in IDLE.
  - REQ: req_out=1. When ack_sync==1, go to DROP.
  - DROP: req_out=0. When ack_sync==0, go to IDLE and pulse done_pulse for 1 cycle.
- ch_out holds its value from REQ entry until the next REQ entry. It is never modified while req_out=1.
- overflow[i] is sticky until clr_ovf=1. If clr_ovf and a new overflow occur in the same cycle, the set wins.
- Reset values: req_out=0, ch_out=0, done_pulse=0, busy=0, overflow=0, all pend=0, all sync flops=0, state=IDLE.
- Reset mid-handshake: everything returns to reset values immediately and pending events are discarded. The remote side must be reset together with this block.

## Timing
- req_out, ch_out, busy, done_pulse and overflow are all flop outputs. No combinational path exists from any input to any output.
- pulse_in[i] sampled at edge k: pend[i]=1 after edge k; req_out=1 after edge k+1 (FSM idle, ack_sync low). Minimum latency is 2 cycles.
- ack_in rising is seen in ack_sync SYNC_STAGES edges later; the FSM leaves REQ on the following edge. The same applies to ack_in falling in DROP.
- Minimum spacing between consecutive requests: 2*SYNC_STAGES+3 cycles, plus remote response time.
- A channel pulsed every cycle accumulates until saturation. Each handshake drains exactly one event per channel.

## Structure
- Shared package hs_pkg:
  - typedef hs_state_t enum {HS_IDLE, HS_REQ, HS_DROP}
  - constant HS_MIN_SYNC=2
- Sub-module sync_chain #(STAGES): parametrised async-reset flop chain, reset value 0. It is used for ack_in and is reusable by the receiver half.
- The top level holds a generate loop for the per-channel counter and overflow logic, plus the FSM.

## Test plan
- Reset, then pulse_in=4'b0001 once, with a remote model acking 3 cycles after req_out: req_out high 2 cycles after the pulse; ch_out=0001; one done_pulse; busy low afterwards.
- pulse_in=4'b0101 while in REQ: after done_pulse, a second request with ch_out=0101; pend returns to 0.
- Channel 2 pulsed 20 times during one held handshake (CNT_W=4): pend[2]=15, overflow[2]=1. After 15 handshakes pend[2]=0; clr_ovf clears the flag.
- ack_in held high out of reset, then a pulse: req_out stays 0 until ack_sync falls, then asserts.
- rstb asserted while in REQ: req_out, ch_out and busy go to 0 asynchronously; no done_pulse after rstb is released.
- Simultaneous pulse_in[1] and REQ entry, with pend[1]=1 before the edge: pend[1] stays 1 and a second request follows.
